// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for a single UART transmitter.
// A requester keeps the grant for a whole packet, which ends on its req_last
// byte. Each accepted byte is handed over with a one-cycle tx_start, and the
// arbiter then follows tx_busy until the transmitter has finished the byte.
// A grant is revoked if its holder leaves req_valid low mid-packet for too long.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned HOLD_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 timeout_err
);

   localparam int unsigned   PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned   CW        = $clog2(HOLD_TIMEOUT);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t               state;
   logic [PW-1:0]        last_ptr;
   logic [PW-1:0]        cur_idx;
   logic [CW-1:0]        hold_cnt;
   logic                 last_flag;

   logic [PW-1:0]        scan_idx;
   logic [PW-1:0]        pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic                 pick_found;

   logic [7:0]           sel_data;
   logic                 sel_valid;
   logic                 sel_last;

   // Search upward from last_ptr+1 (wrapping) for the first valid requester
   always_comb begin
      pick_found  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      scan_idx    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx = PW'((32'(last_ptr) + k) % NUM_REQ);
         if (!pick_found && req_valid[scan_idx]) begin
            pick_found            = 1'b1;
            pick_idx              = scan_idx;
            pick_onehot           = '0;
            pick_onehot[scan_idx] = 1'b1;
         end
      end
   end

   // Route the current owner's byte, valid and last flag
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (32'(cur_idx) == k) begin
            sel_data  = req_data[8*k +: 8];
            sel_valid = req_valid[k];
            sel_last  = req_last[k];
         end
      end
   end

   // The owner may hand over a byte only while the arbiter is in GRANT
   always_comb begin
      req_ready = (state == GRANT) ? grant : '0;
   end

   // Arbitration and transmit handshake state machine with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         cur_idx     <= '0;
         last_ptr    <= LAST_IDX;
         hold_cnt    <= '0;
         last_flag   <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         timeout_err <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_found) begin
                  grant    <= pick_onehot;
                  cur_idx  <= pick_idx;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (sel_valid) begin
                  tx_data   <= sel_data;
                  last_flag <= sel_last;
                  hold_cnt  <= '0;
                  tx_start  <= 1'b1;
                  state     <= START;
               end else if (hold_cnt == HOLD_LAST) begin
                  grant       <= '0;
                  last_ptr    <= cur_idx;
                  hold_cnt    <= '0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            START: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_flag) begin
                     grant    <= '0;
                     last_ptr <= cur_idx;
                     state    <= IDLE;
                  end else begin
                     state <= GRANT;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of one-byte packets plus
// hand-written sequences for packet lock, rotation, hold timeout, reset
// during a transfer and a slow busy handshake.
module tb_uart_tx_arbiter;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy   = 1'b0;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // transmitter model state
   int starts     = 0;
   int falls      = 0;
   int fall_cyc   = 0;
   int busy_delay = 1;
   int busy_len   = 20;
   int dcnt       = 0;
   int rem        = 0;

   typedef struct {
      logic [3:0] mask;
      logic [7:0] base;
      logic [3:0] exp_grant;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   uart_tx_arbiter #(
      .NUM_REQ      (4),
      .HOLD_TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Cycle index, advanced on every active edge
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy rises busy_delay cycles after tx_start, lasts busy_len cycles
   always @(negedge clk) begin
      if (tx_start) begin
         starts = starts + 1;
         dcnt   = busy_delay;
      end else if (dcnt != 0) begin
         dcnt = dcnt - 1;
         if (dcnt == 0) begin
            tx_busy = 1'b1;
            rem     = busy_len;
         end
      end else if (tx_busy) begin
         rem = rem - 1;
         if (rem == 0) begin
            tx_busy  = 1'b0;
            falls    = falls + 1;
            fall_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic at_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
      req_valid[i]       = v;
      req_data[8*i +: 8] = d;
      req_last[i]        = l;
   endtask

   task automatic wait_fall(input string name, input int target);
      int ok;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         if (falls >= target) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk(name, ok, 1);
   endtask

   task automatic do_reset();
      at_edge();
      reset = 1'b1;
      repeat (2) at_edge();
      reset = 1'b0;
   endtask

   // One single-byte packet per valid requester in mask; returns with the arbiter idle
   task automatic run_vec(input int n, input vec_t v);
      int s0;
      int f0;
      at_edge();
      for (int i = 0; i < 4; i++) set_req(i, v.mask[i], v.base + 8'(i), 1'b1);
      s0 = starts;
      f0 = falls;
      tick();
      chk($sformatf("v%0d idle grant", n), grant, 4'b0000);
      tick();
      chk($sformatf("v%0d grant", n), grant, v.exp_grant);
      chk($sformatf("v%0d ready", n), req_ready, v.exp_grant);
      at_edge();
      req_valid = '0;
      tick();
      chk($sformatf("v%0d tx_start", n), tx_start, 1'b1);
      chk($sformatf("v%0d tx_data", n), tx_data, v.exp_data);
      wait_fall($sformatf("v%0d busy fall", n), f0 + 1);
      chk($sformatf("v%0d grant held", n), grant, v.exp_grant);
      tick();
      chk($sformatf("v%0d grant released", n), grant, 4'b0000);
      chk($sformatf("v%0d start count", n), starts - s0, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] lock_bytes[3];
      int         exp_idx[5];
      int         ok;
      int         ng;
      int         sic;
      int         s0;
      int         f0;
      logic [3:0] prev;

      vecs[0]  = '{4'b0100, 8'hA3, 4'b0100, 8'hA5};
      vecs[1]  = '{4'b1111, 8'h10, 4'b1000, 8'h13};
      vecs[2]  = '{4'b1111, 8'h20, 4'b0001, 8'h20};
      vecs[3]  = '{4'b1111, 8'h30, 4'b0010, 8'h31};
      vecs[4]  = '{4'b1111, 8'h40, 4'b0100, 8'h42};
      vecs[5]  = '{4'b1111, 8'h50, 4'b1000, 8'h53};
      vecs[6]  = '{4'b1111, 8'h60, 4'b0001, 8'h60};
      vecs[7]  = '{4'b0101, 8'h70, 4'b0100, 8'h72};
      vecs[8]  = '{4'b0101, 8'h80, 4'b0001, 8'h80};
      vecs[9]  = '{4'b0011, 8'h90, 4'b0010, 8'h91};
      vecs[10] = '{4'b0001, 8'hB0, 4'b0001, 8'hB0};
      lock_bytes = '{8'h11, 8'h22, 8'h33};
      exp_idx    = '{0, 1, 2, 3, 0};

      repeat (3) at_edge();
      reset = 1'b0;
      tick();
      chk("reset grant", grant, 4'b0000);
      chk("reset ready", req_ready, 4'b0000);
      chk("reset tx_start", tx_start, 1'b0);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset timeout_err", timeout_err, 1'b0);

      busy_delay = 1;
      busy_len   = 20;
      for (int n = 0; n < 11; n++) run_vec(n, vecs[n]);

      // packet lock: requester 1 sends three bytes while requester 0 waits
      busy_len = 6;
      at_edge();
      req_valid = '0;
      set_req(1, 1'b1, 8'h11, 1'b0);
      set_req(0, 1'b1, 8'hF0, 1'b1);
      tick();
      tick();
      chk("lock grant", grant, 4'b0010);
      for (int k = 0; k < 3; k++) begin
         ok = 0;
         for (int n = 0; n < 50; n++) begin
            if (req_ready[1]) begin
               ok = 1;
               break;
            end
            tick();
         end
         chk($sformatf("lock ready %0d", k), ok, 1);
         f0 = falls;
         at_edge();
         if (k == 0) set_req(1, 1'b1, 8'h22, 1'b0);
         else if (k == 1) set_req(1, 1'b1, 8'h33, 1'b1);
         else set_req(1, 1'b0, 8'h00, 1'b0);
         tick();
         chk($sformatf("lock tx_start %0d", k), tx_start, 1'b1);
         chk($sformatf("lock tx_data %0d", k), tx_data, lock_bytes[k]);
         chk($sformatf("lock grant %0d", k), grant, 4'b0010);
         if (k > 0) chk($sformatf("lock restart gap %0d", k), cyc - fall_cyc, 2);
         wait_fall($sformatf("lock busy fall %0d", k), f0 + 1);
      end
      chk("lock grant at last fall", grant, 4'b0010);
      tick();
      chk("lock grant released", grant, 4'b0000);
      tick();
      chk("lock next grant", grant, 4'b0001);
      f0 = falls;
      at_edge();
      set_req(0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("lock req0 tx_start", tx_start, 1'b1);
      chk("lock req0 tx_data", tx_data, 8'hF0);
      wait_fall("lock req0 busy fall", f0 + 1);
      tick();
      chk("lock req0 released", grant, 4'b0000);
      tick();

      // continuous round-robin after reset
      do_reset();
      busy_len = 3;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hC0 + 8'(i), 1'b1);
      ng   = 0;
      sic  = 0;
      ok   = 0;
      prev = '0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (tx_start) begin
            sic++;
            if (ng > 0 && ng <= 5) chk("rr tx_data", tx_data, 8'hC0 + 8'(exp_idx[ng-1]));
         end
         if (grant != 4'b0000 && prev == 4'b0000) begin
            if (ng > 0) chk("rr starts per grant", sic, 1);
            if (ng < 5) chk($sformatf("rr grant %0d", ng), grant, 1 << exp_idx[ng]);
            ng++;
            sic = 0;
         end
         prev = grant;
         if (ng >= 5 && sic == 1) begin
            ok = 1;
            break;
         end
      end
      chk("rr five grants", ok, 1);
      at_edge();
      req_valid = '0;
      ok = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (grant == 4'b0000 && !tx_busy) begin
            ok = 1;
            break;
         end
      end
      chk("rr drain", ok, 1);
      tick();

      // hold timeout on requester 3 after requester 1 last owned the line
      do_reset();
      busy_len = 4;
      run_vec(11, '{4'b0010, 8'h00, 4'b0010, 8'h01});
      at_edge();
      set_req(3, 1'b1, 8'h3C, 1'b0);
      tick();
      tick();
      chk("to grant", grant, 4'b1000);
      f0 = falls;
      at_edge();
      set_req(3, 1'b0, 8'h00, 1'b0);
      tick();
      chk("to tx_start", tx_start, 1'b1);
      chk("to tx_data", tx_data, 8'h3C);
      wait_fall("to busy fall", f0 + 1);
      tick();
      chk("to regrant", grant, 4'b1000);
      chk("to ready", req_ready, 4'b1000);
      repeat (7) tick();
      chk("to no early pulse", timeout_err, 1'b0);
      chk("to grant still held", grant, 4'b1000);
      tick();
      chk("to pulse", timeout_err, 1'b1);
      chk("to grant cleared", grant, 4'b0000);
      tick();
      chk("to pulse one cycle", timeout_err, 1'b0);
      run_vec(12, '{4'b0110, 8'h4A, 4'b0010, 8'h4B});

      // reset while the transmitter is busy
      busy_len = 20;
      at_edge();
      set_req(2, 1'b1, 8'h5A, 1'b1);
      tick();
      tick();
      chk("rst grant", grant, 4'b0100);
      f0 = falls;
      at_edge();
      req_valid = '0;
      tick();
      chk("rst tx_start", tx_start, 1'b1);
      repeat (3) tick();
      chk("rst busy seen", tx_busy, 1'b1);
      at_edge();
      reset = 1'b1;
      at_edge();
      reset = 1'b0;
      tick();
      chk("rst grant zero", grant, 4'b0000);
      chk("rst ready zero", req_ready, 4'b0000);
      chk("rst tx_start zero", tx_start, 1'b0);
      chk("rst tx_data zero", tx_data, 8'h00);
      chk("rst timeout_err zero", timeout_err, 1'b0);
      s0 = starts;
      wait_fall("rst busy fall", f0 + 1);
      repeat (10) tick();
      chk("rst no resend", starts - s0, 0);
      chk("rst stays idle", grant, 4'b0000);

      // slow busy handshake
      busy_delay = 3;
      busy_len   = 5;
      at_edge();
      set_req(0, 1'b1, 8'h77, 1'b1);
      tick();
      tick();
      chk("hs grant", grant, 4'b0001);
      f0 = falls;
      at_edge();
      req_valid = '0;
      tick();
      chk("hs tx_start", tx_start, 1'b1);
      s0 = starts;
      for (int j = 1; j <= 3; j++) begin
         tick();
         chk($sformatf("hs no restart %0d", j), tx_start, 1'b0);
         chk($sformatf("hs grant held %0d", j), grant, 4'b0001);
         chk($sformatf("hs data stable %0d", j), tx_data, 8'h77);
      end
      wait_fall("hs busy fall", f0 + 1);
      chk("hs single start", starts - s0, 0);
      chk("hs grant until fall", grant, 4'b0001);
      tick();
      chk("hs grant released", grant, 4'b0000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
